// File: rtl/rs_flag_arbiter_pkg.sv
// Shared constants and helpers for the round-robin set/reset flag arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rs_flag_pkg;

  // Command encoding carried on cmd_set.
  localparam logic CMD_CLR = 1'b0;
  localparam logic CMD_SET = 1'b1;

  // Index width for a vector of n entries.
  // Never returns less than 1, so a 1- or 2-entry vector still gets a real bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rs_flag_arbiter_if.sv
// Requester-side bundle for rs_flag_arbiter: commands in, grant/flags/status out.
// Latency: gnt/flags/err are registered, one edge after the command is sampled; busy is combinational.
// Backpressure: req is held until gnt pulses, and cmd_set/cmd_idx stay stable while pending.
//
// Signals:
//   req      [NREQ]        per-requester command valid
//   cmd_set  [NREQ]        1 = set flag, 0 = clear flag
//   cmd_idx  [NREQ*IDXW]   flag index, requester r at [r*IDXW +: IDXW]
//   clr_all                one-cycle pulse, clear every flag
//   gnt      [NREQ]        one-hot grant pulse
//   flags    [NFLAG]       flag bank
//   err                    granted command addressed a nonexistent flag
//   busy                   any requester active
interface rs_flag_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8
);
  localparam int IDXW = rs_flag_pkg::clog2_min1(NFLAG);

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      cmd_set;
  logic [NREQ*IDXW-1:0] cmd_idx;
  logic                 clr_all;
  logic [NREQ-1:0]      gnt;
  logic [NFLAG-1:0]     flags;
  logic                 err;
  logic                 busy;

  // Requester side.
  modport master (
    output req, cmd_set, cmd_idx, clr_all,
    input  gnt, flags, err, busy
  );

  // Arbiter side.
  modport slave (
    input  req, cmd_set, cmd_idx, clr_all,
    output gnt, flags, err, busy
  );

endinterface

// File: rtl/rs_flag_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow the inputs.
//
// Ports:
//   eligible [N]   candidates this cycle
//   ptr      [PW]  highest-priority position
//   onehot   [N]   selected candidate
//   idx      [PW]  binary index of the selected candidate
//   any            at least one candidate was eligible
module rr_pick
  import rs_flag_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  eligible,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          any
);

  always_comb begin : scan
    logic [PW-1:0] pos;
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    pos    = '0;
    // Walk offsets 0..N-1 from the pointer; the first hit locks out later ones.
    // Modulo keeps the wrap correct when N is not a power of two.
    for (int off = 0; off < N; off++) begin
      pos = PW'((int'(ptr) + off) % N);
      if (!any && eligible[pos]) begin
        any         = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos;
      end
    end
  end

endmodule

// File: rtl/rs_flag_arbiter.sv
// Bank of NFLAG set/reset flags written by NREQ requesters, one granted command per cycle, round-robin.
// Latency: command sampled at edge t; gnt, the flag update and err are all visible after edge t.
// Backpressure: requesters hold req until their one-cycle gnt pulse; a requester granted this
//               cycle is masked for one edge so it can drop req or present its next command.
//
// Ports:
//   clk    rising-edge system clock
//   reset  synchronous active-high reset (flags, grant, err, pointer cleared)
//   bus    slave side of rs_flag_arbiter_if (req/cmd_set/cmd_idx/clr_all in,
//          gnt/flags/err/busy out)
module rs_flag_arbiter
  import rs_flag_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8
) (
  input  logic               clk,
  input  logic               reset,
  rs_flag_arbiter_if.slave   bus
);

  localparam int IDXW = clog2_min1(NFLAG);
  localparam int PW   = clog2_min1(NREQ);

  // One bit wider than an index so NFLAG itself is representable.
  localparam logic [IDXW:0] FLAG_LIM = (IDXW + 1)'(NFLAG);

  logic [NREQ-1:0]  gnt_q,   gnt_d;
  logic [PW-1:0]    ptr_q,   ptr_d;
  logic [NFLAG-1:0] flags_q, flags_d;
  logic             err_q,   err_d;

  logic [NREQ-1:0]  eligible;
  logic [NREQ-1:0]  pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;

  logic [IDXW-1:0]  idx_arr [NREQ];
  logic [IDXW-1:0]  win_fidx;
  logic             win_set;
  logic             win_bad;

  // Last cycle's winner is masked so its held-over req cannot win twice
  // while it is still deasserting.
  assign eligible = bus.req & ~gnt_q;

  rr_pick #(
    .N  (NREQ),
    .PW (PW)
  ) u_pick (
    .eligible (eligible),
    .ptr      (ptr_q),
    .onehot   (pick_onehot),
    .idx      (pick_idx),
    .any      (pick_any)
  );

  // Winner mux: unpack the flat index bus, then select the granted requester's command.
  always_comb begin
    for (int r = 0; r < NREQ; r++) begin
      idx_arr[r] = bus.cmd_idx[r*IDXW +: IDXW];
    end
  end

  assign win_fidx = idx_arr[pick_idx];
  assign win_set  = bus.cmd_set[pick_idx];
  assign win_bad  = ({1'b0, win_fidx} >= FLAG_LIM);

  always_comb begin
    gnt_d   = pick_onehot;
    ptr_d   = ptr_q;
    err_d   = 1'b0;
    flags_d = flags_q;
    if (pick_any) begin
      ptr_d = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + PW'(1);
      // A bad index is still granted so the requester is released; only the write is dropped.
      if (win_bad) begin
        err_d = 1'b1;
      end else begin
        flags_d[win_fidx] = (win_set == CMD_SET);
      end
    end
    // Bulk clear overrides the single-flag write of the same edge.
    if (bus.clr_all) begin
      flags_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q   <= '0;
      ptr_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.flags = flags_q;
  assign bus.err   = err_q;
  assign bus.busy  = |bus.req;

endmodule

// File: tb/tb_rs_flag_arbiter.sv
// Bench for rs_flag_arbiter: two instances (NFLAG=8 and NFLAG=6) share one stimulus stream.
// Latency: each tick drives inputs mid-cycle and compares outputs 1 time unit after the edge.
// Backpressure: requester emulation holds req and command until the reference model grants it.
module tb_rs_flag_arbiter;

  localparam int NREQ = 4;
  localparam int IDXW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      cmd_set;
  logic [NREQ*IDXW-1:0] cmd_idx;
  logic                 clr_all;

  rs_flag_arbiter_if #(.NREQ(NREQ), .NFLAG(8)) bus8 ();
  rs_flag_arbiter_if #(.NREQ(NREQ), .NFLAG(6)) bus6 ();

  assign bus8.req     = req;
  assign bus8.cmd_set = cmd_set;
  assign bus8.cmd_idx = cmd_idx;
  assign bus8.clr_all = clr_all;
  assign bus6.req     = req;
  assign bus6.cmd_set = cmd_set;
  assign bus6.cmd_idx = cmd_idx;
  assign bus6.clr_all = clr_all;

  rs_flag_arbiter #(.NREQ(NREQ), .NFLAG(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  rs_flag_arbiter #(.NREQ(NREQ), .NFLAG(6)) u_dut6 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus6.slave)
  );

  // Reference model state: what the outputs should be after the last edge.
  int          m_ptr;
  logic [3:0]  m_gnt;
  logic [7:0]  m_f8;
  logic [5:0]  m_f6;
  logic        m_e8;
  logic        m_e6;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Apply the arbitration and flag rules to the inputs presented for the next edge.
  task automatic model_step();
    int win;
    int idx;
    if (reset) begin
      m_ptr = 0;
      m_gnt = '0;
      m_f8  = '0;
      m_f6  = '0;
      m_e8  = 1'b0;
      m_e6  = 1'b0;
    end else begin
      win = -1;
      for (int k = 0; k < NREQ; k++) begin
        int r;
        r = (m_ptr + k) % NREQ;
        if (win < 0 && req[r] && !m_gnt[r]) win = r;
      end
      m_gnt = '0;
      m_e8  = 1'b0;
      m_e6  = 1'b0;
      if (win >= 0) begin
        m_gnt[win] = 1'b1;
        m_ptr      = (win + 1) % NREQ;
        idx        = int'(cmd_idx[win*IDXW +: IDXW]);
        if (idx < 8) m_f8[idx] = cmd_set[win]; else m_e8 = 1'b1;
        if (idx < 6) m_f6[idx] = cmd_set[win]; else m_e6 = 1'b1;
      end
      if (clr_all) begin
        m_f8 = '0;
        m_f6 = '0;
      end
    end
  endtask

  // One clock: check busy on the driven inputs, advance the model, compare after the edge.
  task automatic tick();
    #1;
    chk("busy8", bus8.busy, |req);
    chk("busy6", bus6.busy, |req);
    model_step();
    @(posedge clk);
    #1;
    chk("gnt8",   bus8.gnt,   m_gnt);
    chk("gnt6",   bus6.gnt,   m_gnt);
    chk("flags8", bus8.flags, m_f8);
    chk("flags6", bus6.flags, m_f6);
    chk("err8",   bus8.err,   m_e8);
    chk("err6",   bus6.err,   m_e6);
  endtask

  task automatic set_cmd(input int r, input logic s, input int idx);
    cmd_set[r] = s;
    cmd_idx[r*IDXW +: IDXW] = idx[IDXW-1:0];
  endtask

  task automatic new_cmd(input int r);
    req[r] = 1'b1;
    set_cmd(r, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
  endtask

  logic [3:0] exp_seq [5];

  initial begin
    reset   = 1'b1;
    req     = '0;
    cmd_set = '0;
    cmd_idx = '0;
    clr_all = 1'b0;
    m_ptr   = 0;
    m_gnt   = '0;
    m_f8    = '0;
    m_f6    = '0;
    m_e8    = 1'b0;
    m_e6    = 1'b0;

    // Reset held with every requester active; nothing may be granted.
    req = 4'hF;
    for (int r = 0; r < NREQ; r++) set_cmd(r, 1'b1, r);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_gnt",   bus8.gnt,   4'h0);
      chk("rst_flags", bus8.flags, 8'h00);
      chk("rst_err",   bus8.err,   1'b0);
    end

    // Round-robin with all requesters held: grants rotate 0,1,2,3,0.
    reset = 1'b0;
    exp_seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rr_gnt", bus8.gnt, exp_seq[i]);
      if (i == 3) begin
        chk("rr_flags8", bus8.flags, 8'h0F);
        chk("rr_flags6", bus6.flags, 6'h0F);
      end
    end
    req = '0;
    tick();

    // Opposite commands to the same flag: req0 set wins first, req1 clear overwrites.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_cmd(0, 1'b1, 3);
    set_cmd(1, 1'b0, 3);
    req = 4'b0011;
    tick();
    chk("conf_gnt0", bus8.gnt, 4'b0001);
    chk("conf_set",  bus8.flags[3], 1'b1);
    req = 4'b0010;
    tick();
    chk("conf_gnt1", bus8.gnt, 4'b0010);
    chk("conf_clr",  bus8.flags[3], 1'b0);
    req = '0;
    tick();

    // Fill every flag, then race clr_all against a set from req2.
    for (int i = 0; i < 8; i++) begin
      set_cmd(0, 1'b1, i);
      req = 4'b0001;
      tick();
      req = '0;
      tick();
    end
    chk("fill_flags8", bus8.flags, 8'hFF);
    set_cmd(2, 1'b1, 5);
    req     = 4'b0100;
    clr_all = 1'b1;
    tick();
    chk("clr_gnt",    bus8.gnt,   4'b0100);
    chk("clr_flags8", bus8.flags, 8'h00);
    chk("clr_flags6", bus6.flags, 6'h00);
    clr_all = 1'b0;
    req     = '0;
    tick();

    // Index 7 is out of range for the 6-flag instance: granted, err pulses, no write.
    set_cmd(1, 1'b1, 7);
    req = 4'b0010;
    tick();
    chk("bad_gnt",    bus6.gnt,   4'b0010);
    chk("bad_err",    bus6.err,   1'b1);
    chk("bad_flags6", bus6.flags, 6'h00);
    chk("ok_flags8",  bus8.flags, 8'h80);
    req = '0;
    tick();
    chk("bad_err_end", bus6.err, 1'b0);

    // Withdrawal: req3 drops before its turn and leaves no trace.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_cmd(0, 1'b1, 1);
    set_cmd(3, 1'b1, 2);
    req = 4'b1001;
    tick();
    chk("wd_gnt0", bus8.gnt, 4'b0001);
    req = '0;
    tick();
    chk("wd_nognt", bus8.gnt,   4'b0000);
    chk("wd_flags", bus8.flags, 8'h02);

    // Mid-operation reset with three commands pending, then pointer restarts at 0.
    set_cmd(1, 1'b1, 4);
    set_cmd(2, 1'b1, 5);
    set_cmd(3, 1'b1, 6);
    req   = 4'b1110;
    reset = 1'b1;
    tick();
    chk("mr_gnt",   bus8.gnt,   4'b0000);
    chk("mr_flags", bus8.flags, 8'h00);
    req = '0;
    tick();
    reset = 1'b0;
    set_cmd(0, 1'b0, 0);
    req = 4'hF;
    tick();
    chk("mr_first", bus8.gnt, 4'b0001);
    req = '0;
    tick();

    // Randomised traffic obeying the hold-until-granted handshake.
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 99) == 0);
      clr_all = ($urandom_range(0, 15) == 0);
      for (int r = 0; r < NREQ; r++) begin
        if (m_gnt[r]) begin
          if ($urandom_range(0, 1) == 1) new_cmd(r);
          else req[r] = 1'b0;
        end else if (req[r]) begin
          if ($urandom_range(0, 15) == 0) req[r] = 1'b0;
        end else if ($urandom_range(0, 9) < 4) begin
          new_cmd(r);
        end
      end
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
